// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame master and its cycle timer.
package spi_pkg;

    // Frame controller states; SPI clock and chip select are decoded from these.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    // Frame framing bytes used by the sprite/draw command link.
    localparam logic [7:0] SPI_CMD_SPRITE = 8'h00;
    localparam logic [7:0] SPI_CMD_DRAW   = 8'h00;
    localparam logic [7:0] SPI_END_BYTE   = 8'h00;

    // A sprite upload carries this many pixel bytes.
    localparam int SPRITE_PIXEL_BYTES = 512;

    // Width of the phase/delay counter.
    localparam int TIMER_W = 16;

    // Converts a cycle-count parameter into a timer load value.
    function automatic logic [TIMER_W-1:0] timer_len(input int cycles);
        return TIMER_W'(cycles);
    endfunction

endpackage

// File: rtl/spi_sck_timer.sv
// Down-counter that times SCK half-periods and the chip-select setup/hold/idle
// intervals. Loading N makes done true on the N-th cycle after the load.
module spi_sck_timer
    import spi_pkg::*;
(
    input  logic               sys_clock,
    input  logic               sys_reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               done
);

    logic [TIMER_W-1:0] count;

    // Reload on a state change, otherwise count down and rest at zero.
    always_ff @(posedge sys_clock) begin
        if (!sys_reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value - TIMER_W'(1);
        end else if (count != '0) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/spi_frame_master.sv
// SPI master for the sprite/draw command link: takes bytes from a valid/ready
// stream, shifts them out MSB first (SCK idles high, MOSI changes on SCK fall)
// and captures MISO, holding chip select low across a whole frame.
module spi_frame_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 1,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 1,
    parameter int CS_IDLE  = 2
)
(
    input  logic       sys_clock,
    input  logic       sys_reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs
);

    spi_state_t         state;
    spi_state_t         state_next;
    logic [7:0]         shift_reg;
    logic [7:0]         rx_shift;
    logic [7:0]         rx_next;
    logic [2:0]         bit_idx;
    logic               last_q;
    logic               ready_q;
    logic               mosi_q;
    logic               sample_q;
    logic               xfer;
    logic               byte_done;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_done;

    spi_sck_timer u_timer (
        .sys_clock   (sys_clock),
        .sys_reset_n (sys_reset_n),
        .load        (timer_load),
        .load_value  (timer_value),
        .done        (timer_done)
    );

    assign xfer      = tx_valid && ready_q;
    assign byte_done = (state == ST_HIGH) && timer_done && (bit_idx == 3'd0);
    assign rx_next   = sample_q ? {rx_shift[6:0], spi_miso} : rx_shift;

    assign tx_ready  = ready_q;
    assign busy      = (state != ST_IDLE);
    assign spi_cs    = (state == ST_IDLE) || (state == ST_GAP);
    assign spi_sck   = (state != ST_LOW);
    assign spi_mosi  = (state == ST_LOW) ? shift_reg[7] : mosi_q;

    // State register; reset drops any partial byte and raises chip select at once.
    always_ff @(posedge sys_clock) begin
        if (!sys_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, plus a timer reload with the length of whichever timed state is entered.
    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    state_next  = ST_SETUP;
                    timer_load  = 1'b1;
                    timer_value = timer_len(CS_SETUP);
                end
            end
            ST_SETUP: begin
                if (timer_done) begin
                    state_next  = ST_LOW;
                    timer_load  = 1'b1;
                    timer_value = timer_len(CLK_DIV);
                end
            end
            ST_LOW: begin
                if (timer_done) begin
                    state_next  = ST_HIGH;
                    timer_load  = 1'b1;
                    timer_value = timer_len(CLK_DIV);
                end
            end
            ST_HIGH: begin
                if (timer_done) begin
                    if (bit_idx != 3'd0) begin
                        state_next  = ST_LOW;
                        timer_load  = 1'b1;
                        timer_value = timer_len(CLK_DIV);
                    end else if (last_q) begin
                        state_next  = ST_HOLD;
                        timer_load  = 1'b1;
                        timer_value = timer_len(CS_HOLD);
                    end else begin
                        state_next  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (xfer) begin
                    state_next  = ST_LOW;
                    timer_load  = 1'b1;
                    timer_value = timer_len(CLK_DIV);
                end
            end
            ST_HOLD: begin
                if (timer_done) begin
                    state_next  = ST_GAP;
                    timer_load  = 1'b1;
                    timer_value = timer_len(CS_IDLE);
                end
            end
            ST_GAP: begin
                if (timer_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Byte datapath: latch on handshake, shift per bit, capture MISO on the first high cycle.
    always_ff @(posedge sys_clock) begin
        if (!sys_reset_n) begin
            shift_reg <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            bit_idx   <= '0;
            last_q    <= 1'b0;
            ready_q   <= 1'b0;
            mosi_q    <= 1'b0;
            sample_q  <= 1'b0;
        end else begin
            ready_q  <= (state_next == ST_IDLE) || (state_next == ST_WAIT);
            sample_q <= (state == ST_LOW) && (state_next == ST_HIGH);
            rx_valid <= byte_done;

            if (xfer) begin
                shift_reg <= tx_data;
                last_q    <= tx_last;
            end else if ((state == ST_HIGH) && timer_done && (bit_idx != 3'd0)) begin
                shift_reg <= {shift_reg[6:0], 1'b0};
            end

            if (((state == ST_SETUP) || (state == ST_WAIT)) && (state_next == ST_LOW)) begin
                bit_idx <= 3'd7;
            end else if ((state == ST_HIGH) && (state_next == ST_LOW)) begin
                bit_idx <= bit_idx - 3'd1;
            end

            if (state == ST_LOW) begin
                mosi_q <= shift_reg[7];
            end

            if (sample_q) begin
                rx_shift <= rx_next;
            end

            if (byte_done) begin
                rx_data <= rx_next;
            end
        end
    end

endmodule
